dac_ad7302_arbiter: RTL and testbench

//   Shares the single AD7302 8-bit dual-output DAC bus between two requesters:

---
 rtl/dac_ctrl_pkg.sv | 34 +++
 rtl/rr_arb2.sv | 34 +++
 rtl/dac_ad7302_arbiter.sv | 134 +++++++++++++
 tb/tb_dac_ad7302_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_ctrl_pkg.sv
// Shared definitions for the AD7302 DAC bus arbiter: state encoding, channel
// codes, default phase timing and the latched DAC word.
package dac_ctrl_pkg;

  localparam int unsigned DATA_W = 8;

  localparam int unsigned DEF_SETUP_CYC = 2;
  localparam int unsigned DEF_WR_CYC    = 3;
  localparam int unsigned DEF_HOLD_CYC  = 2;

  localparam logic CH_A = 1'b0;
  localparam logic CH_B = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_WRITE = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  // Sample and output select as presented on the DAC pins.
  typedef struct packed {
    logic              sel;
    logic [DATA_W-1:0] data;
  } dac_word_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the pointer names the channel preferred
// when both request and moves only when a grant is accepted.
module rr_arb2
  import dac_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  logic ptr_q;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (ptr_q == CH_A) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // After serving a channel, prefer the other one on the next contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= CH_A;
    end else if (accept) begin
      ptr_q <= grant[0] ? CH_B : CH_A;
    end
  end

endmodule

// File: rtl/dac_ad7302_arbiter.sv
// Shares the AD7302 DAC bus between channel A and B sources: round-robin
// accept, then SETUP / WRITE (DAC_WRN low) / HOLD phases from cycle counts.
module dac_ad7302_arbiter
  import dac_ctrl_pkg::*;
#(
  parameter int unsigned SETUP_CYC = DEF_SETUP_CYC,
  parameter int unsigned WR_CYC    = DEF_WR_CYC,
  parameter int unsigned HOLD_CYC  = DEF_HOLD_CYC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic [DATA_W-1:0] DAC_D,
  output logic              DAC_WRN,
  output logic              DAC_A_B,
  output logic              busy,
  output logic [DATA_W-1:0] last_a,
  output logic [DATA_W-1:0] last_b
);

  localparam int unsigned CNT_W = $clog2(max3(SETUP_CYC, WR_CYC, HOLD_CYC) + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  dac_word_t         word_q, word_d;
  logic              wrn_q, wrn_d;
  logic [DATA_W-1:0] last_a_q, last_a_d;
  logic [DATA_W-1:0] last_b_q, last_b_d;
  logic [1:0]        grant;
  logic              idle;
  logic              accept;
  logic              cnt_last;

  assign idle     = (state_q == ST_IDLE);
  assign accept   = idle & (|grant);
  assign cnt_last = (cnt_q == CNT_W'(1));

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({b_valid, a_valid}),
    .accept (accept),
    .grant  (grant)
  );

  // Next-state and next-output logic; every phase ends when its counter reaches 1.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    word_d   = word_q;
    wrn_d    = wrn_q;
    last_a_d = last_a_q;
    last_b_d = last_b_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d     = ST_SETUP;
          cnt_d       = CNT_W'(SETUP_CYC);
          word_d.sel  = grant[1] ? CH_B : CH_A;
          word_d.data = grant[1] ? b_data : a_data;
        end
      end
      ST_SETUP: begin
        if (cnt_last) begin
          state_d = ST_WRITE;
          cnt_d   = CNT_W'(WR_CYC);
          wrn_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_WRITE: begin
        if (cnt_last) begin
          state_d = ST_HOLD;
          cnt_d   = CNT_W'(HOLD_CYC);
          wrn_d   = 1'b1;
          if (word_q.sel == CH_B) begin
            last_b_d = word_q.data;
          end else begin
            last_a_d = word_q.data;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_last) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        wrn_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      word_q   <= '0;
      wrn_q    <= 1'b1;
      last_a_q <= '0;
      last_b_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      word_q   <= word_d;
      wrn_q    <= wrn_d;
      last_a_q <= last_a_d;
      last_b_q <= last_b_d;
    end
  end

  assign a_ready = idle & grant[0];
  assign b_ready = idle & grant[1];
  assign DAC_D   = word_q.data;
  assign DAC_A_B = word_q.sel;
  assign DAC_WRN = wrn_q;
  assign busy    = ~idle;
  assign last_a  = last_a_q;
  assign last_b  = last_b_q;

endmodule

// File: tb/tb_dac_ad7302_arbiter.sv
// Directed bench for dac_ad7302_arbiter: default-timing instance plus a
// 1/1/1-cycle instance, checked against hand-derived cycle expectations.
module tb_dac_ad7302_arbiter;

  logic       clk;
  logic       rst_n;
  logic       a_valid, b_valid, a_ready, b_ready;
  logic [7:0] a_data, b_data;
  logic [7:0] dac_d, last_a, last_b;
  logic       dac_wrn, dac_a_b, busy;

  logic       f_a_valid, f_b_valid, f_a_ready, f_b_ready;
  logic [7:0] f_a_data, f_b_data;
  logic [7:0] f_dac_d, f_last_a, f_last_b;
  logic       f_dac_wrn, f_dac_a_b, f_busy;

  int vectors;
  int miscompares;

  dac_ad7302_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .DAC_D(dac_d), .DAC_WRN(dac_wrn), .DAC_A_B(dac_a_b),
    .busy(busy), .last_a(last_a), .last_b(last_b)
  );

  dac_ad7302_arbiter #(.SETUP_CYC(1), .WR_CYC(1), .HOLD_CYC(1)) dut_f (
    .clk(clk), .rst_n(rst_n),
    .a_valid(f_a_valid), .a_data(f_a_data), .a_ready(f_a_ready),
    .b_valid(f_b_valid), .b_data(f_b_data), .b_ready(f_b_ready),
    .DAC_D(f_dac_d), .DAC_WRN(f_dac_wrn), .DAC_A_B(f_dac_a_b),
    .busy(f_busy), .last_a(f_last_a), .last_b(f_last_b)
  );

  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; a_data = 8'h00; b_data = 8'h00;
    f_a_valid = 1'b0; f_b_valid = 1'b0; f_a_data = 8'h00; f_b_data = 8'h00;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    repeat (2) tick();
    vectors++;
    if (dac_wrn !== 1'b1 || dac_d !== 8'h00 || dac_a_b !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: wrn=%b d=%h ab=%b busy=%b, want 1 00 0 0",
               dac_wrn, dac_d, dac_a_b, busy);
    end
    vectors++;
    if (last_a !== 8'h00 || last_b !== 8'h00 || f_dac_wrn !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_last: last_a=%h last_b=%h f_wrn=%b, want 00 00 1",
               last_a, last_b, f_dac_wrn);
    end
    rst_n = 1'b1;
    tick();
    vectors++;
    if (a_ready !== 1'b0 || b_ready !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: a_ready=%b b_ready=%b busy=%b, want 0 0 0",
               a_ready, b_ready, busy);
    end
  endtask

  task automatic test_single_a();
    logic exp_wrn;
    a_data = 8'h80; a_valid = 1'b1;
    #1;
    vectors++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL single_ready: a_ready=%b b_ready=%b, want 1 0", a_ready, b_ready);
    end
    tick();
    a_valid = 1'b0;
    vectors++;
    if (dac_d !== 8'h80 || dac_a_b !== 1'b0 || busy !== 1'b1 || a_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL single_latch: d=%h ab=%b busy=%b a_ready=%b, want 80 0 1 0",
               dac_d, dac_a_b, busy, a_ready);
    end
    for (int i = 2; i <= 8; i++) begin
      tick();
      exp_wrn = (i >= 3 && i <= 5) ? 1'b0 : 1'b1;
      vectors++;
      if (dac_wrn !== exp_wrn) begin
        miscompares++;
        $display("FAIL single_wrn_c%0d: wrn=%b, want %b", i, dac_wrn, exp_wrn);
      end
      if (i == 5) begin
        vectors++;
        if (last_a !== 8'h00) begin
          miscompares++;
          $display("FAIL single_last_early: last_a=%h, want 00", last_a);
        end
      end
      if (i == 6) begin
        vectors++;
        if (last_a !== 8'h80) begin
          miscompares++;
          $display("FAIL single_last: last_a=%h, want 80", last_a);
        end
      end
      if (i == 8) begin
        vectors++;
        if (busy !== 1'b0) begin
          miscompares++;
          $display("FAIL single_done: busy=%b, want 0", busy);
        end
      end
    end
  endtask

  task automatic test_alternate();
    logic exp_b;
    do_reset();
    a_data = 8'h11; b_data = 8'h22;
    a_valid = 1'b1; b_valid = 1'b1;
    for (int w = 0; w < 4; w++) begin
      exp_b = w[0];
      #1;
      vectors++;
      if (a_ready !== ~exp_b || b_ready !== exp_b) begin
        miscompares++;
        $display("FAIL alt_grant_w%0d: a_ready=%b b_ready=%b, want %b %b",
                 w, a_ready, b_ready, ~exp_b, exp_b);
      end
      tick();
      vectors++;
      if (dac_a_b !== exp_b || dac_d !== (exp_b ? 8'h22 : 8'h11)) begin
        miscompares++;
        $display("FAIL alt_latch_w%0d: ab=%b d=%h, want %b %h",
                 w, dac_a_b, dac_d, exp_b, exp_b ? 8'h22 : 8'h11);
      end
      tick();
      vectors++;
      if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL alt_wait_w%0d: a_ready=%b b_ready=%b, want 0 0", w, a_ready, b_ready);
      end
      repeat (4) tick();
      vectors++;
      if ((exp_b ? last_b : last_a) !== (exp_b ? 8'h22 : 8'h11)) begin
        miscompares++;
        $display("FAIL alt_last_w%0d: last=%h, want %h",
                 w, exp_b ? last_b : last_a, exp_b ? 8'h22 : 8'h11);
      end
      if (w == 3) begin
        a_valid = 1'b0; b_valid = 1'b0;
      end
      repeat (2) tick();
    end
    vectors++;
    if (last_a !== 8'h11 || last_b !== 8'h22 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL alt_final: last_a=%h last_b=%h busy=%b, want 11 22 0",
               last_a, last_b, busy);
    end
  endtask

  task automatic test_b_only();
    logic [7:0] vals [4];
    vals[0] = 8'hFF; vals[1] = 8'h00; vals[2] = 8'h7F; vals[3] = 8'h01;
    do_reset();
    b_valid = 1'b1;
    for (int w = 0; w < 4; w++) begin
      b_data = vals[w];
      #1;
      vectors++;
      if (b_ready !== 1'b1 || a_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bonly_ready_w%0d: b_ready=%b a_ready=%b, want 1 0", w, b_ready, a_ready);
      end
      tick();
      b_data = ~vals[w];
      vectors++;
      if (dac_d !== vals[w] || dac_a_b !== 1'b1) begin
        miscompares++;
        $display("FAIL bonly_latch_w%0d: d=%h ab=%b, want %h 1", w, dac_d, dac_a_b, vals[w]);
      end
      for (int c = 2; c <= 8; c++) begin
        tick();
        vectors++;
        if (a_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL bonly_a_ready_w%0d_c%0d: a_ready=%b, want 0", w, c, a_ready);
        end
        if (c == 6) begin
          vectors++;
          if (last_b !== vals[w] || dac_d !== vals[w]) begin
            miscompares++;
            $display("FAIL bonly_last_w%0d: last_b=%h d=%h, want %h %h",
                     w, last_b, dac_d, vals[w], vals[w]);
          end
        end
      end
    end
    b_valid = 1'b0;
    tick();
  endtask

  task automatic test_data_change();
    do_reset();
    a_data = 8'h10; a_valid = 1'b1;
    #1;
    vectors++;
    if (a_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL chg_ready: a_ready=%b, want 1", a_ready);
    end
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 3) a_data = 8'h20;
      vectors++;
      if (dac_d !== 8'h10) begin
        miscompares++;
        $display("FAIL chg_hold_c%0d: d=%h, want 10", c, dac_d);
      end
    end
    tick();
    vectors++;
    if (a_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL chg_reaccept: a_ready=%b busy=%b, want 1 0", a_ready, busy);
    end
    tick();
    a_valid = 1'b0;
    vectors++;
    if (dac_d !== 8'h20 || last_a !== 8'h10) begin
      miscompares++;
      $display("FAIL chg_new: d=%h last_a=%h, want 20 10", dac_d, last_a);
    end
    repeat (7) tick();
    vectors++;
    if (busy !== 1'b0 || last_a !== 8'h20) begin
      miscompares++;
      $display("FAIL chg_done: busy=%b last_a=%h, want 0 20", busy, last_a);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    a_data = 8'h55; a_valid = 1'b1;
    #1;
    tick();
    a_valid = 1'b0;
    repeat (3) tick();
    vectors++;
    if (dac_wrn !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_in_write: wrn=%b, want 0", dac_wrn);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (dac_wrn !== 1'b1 || dac_d !== 8'h00 || dac_a_b !== 1'b0 || busy !== 1'b0 ||
        last_a !== 8'h00) begin
      miscompares++;
      $display("FAIL mid_async: wrn=%b d=%h ab=%b busy=%b last_a=%h, want 1 00 0 0 00",
               dac_wrn, dac_d, dac_a_b, busy, last_a);
    end
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    vectors++;
    if (last_a !== 8'h00 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_discard: last_a=%h busy=%b, want 00 0", last_a, busy);
    end
    a_data = 8'h66; b_data = 8'h77; a_valid = 1'b1; b_valid = 1'b1;
    #1;
    vectors++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_ptr: a_ready=%b b_ready=%b, want 1 0", a_ready, b_ready);
    end
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    vectors++;
    if (dac_d !== 8'h66 || dac_a_b !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_after: d=%h ab=%b, want 66 0", dac_d, dac_a_b);
    end
    repeat (7) tick();
  endtask

  task automatic test_fast();
    logic       exp_b;
    logic [7:0] exp_d;
    logic [7:0] prev_d;
    logic       prev_ab;
    do_reset();
    f_a_data = 8'h3C; f_b_data = 8'hC3;
    f_a_valid = 1'b1; f_b_valid = 1'b1;
    for (int w = 0; w < 4; w++) begin
      exp_b = w[0];
      exp_d = exp_b ? 8'hC3 : 8'h3C;
      #1;
      vectors++;
      if (f_a_ready !== ~exp_b || f_b_ready !== exp_b || f_busy !== 1'b0) begin
        miscompares++;
        $display("FAIL fast_grant_w%0d: a_ready=%b b_ready=%b busy=%b, want %b %b 0",
                 w, f_a_ready, f_b_ready, f_busy, ~exp_b, exp_b);
      end
      tick();
      vectors++;
      if (f_dac_d !== exp_d || f_dac_a_b !== exp_b || f_dac_wrn !== 1'b1) begin
        miscompares++;
        $display("FAIL fast_setup_w%0d: d=%h ab=%b wrn=%b, want %h %b 1",
                 w, f_dac_d, f_dac_a_b, f_dac_wrn, exp_d, exp_b);
      end
      prev_d = f_dac_d; prev_ab = f_dac_a_b;
      tick();
      vectors++;
      if (f_dac_wrn !== 1'b0 || f_dac_d !== prev_d || f_dac_a_b !== prev_ab) begin
        miscompares++;
        $display("FAIL fast_write_w%0d: wrn=%b d=%h ab=%b, want 0 %h %b",
                 w, f_dac_wrn, f_dac_d, f_dac_a_b, prev_d, prev_ab);
      end
      tick();
      vectors++;
      if (f_dac_wrn !== 1'b1 || f_dac_d !== prev_d || f_dac_a_b !== prev_ab ||
          (exp_b ? f_last_b : f_last_a) !== exp_d) begin
        miscompares++;
        $display("FAIL fast_hold_w%0d: wrn=%b d=%h ab=%b last=%h, want 1 %h %b %h",
                 w, f_dac_wrn, f_dac_d, f_dac_a_b, exp_b ? f_last_b : f_last_a,
                 prev_d, prev_ab, exp_d);
      end
      if (w == 3) begin
        f_a_valid = 1'b0; f_b_valid = 1'b0;
      end
      tick();
    end
    vectors++;
    if (f_busy !== 1'b0 || f_last_a !== 8'h3C || f_last_b !== 8'hC3) begin
      miscompares++;
      $display("FAIL fast_final: busy=%b last_a=%h last_b=%h, want 0 3c c3",
               f_busy, f_last_a, f_last_b);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    clk = 1'b0;
    rst_n = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; a_data = 8'h00; b_data = 8'h00;
    f_a_valid = 1'b0; f_b_valid = 1'b0; f_a_data = 8'h00; f_b_data = 8'h00;
    test_reset();
    test_single_a();
    test_alternate();
    test_b_only();
    test_data_change();
    test_reset_mid();
    test_fast();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
